// File: rtl/sequence_generator_moore.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB-first,
// optionally repeating the frame with idle gaps, then pulses done once.
module sequence_generator_moore #(
  parameter int WIDTH = 4,
  parameter int GAP_W = 4,
  parameter int REP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_count,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             sequence_out,
  output logic             sequence_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   pat_reg_q, pat_reg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0]   rep_left_q, rep_left_d;
  logic [GAP_W-1:0]   gap_reg_q, gap_reg_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               sequence_out_q, sequence_out_d;
  logic               sequence_valid_q, sequence_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and datapath logic; outputs are derived from the next state so
  // that every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    pat_reg_d  = pat_reg_q;
    bit_cnt_d  = bit_cnt_q;
    rep_left_d = rep_left_q;
    gap_reg_d  = gap_reg_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = pattern;
          pat_reg_d  = pattern;
          rep_left_d = repeat_count;
          gap_reg_d  = gap_cycles;
          bit_cnt_d  = LAST_BIT;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          if (rep_left_q == '0) begin
            state_d = DONE;
          end else if (gap_reg_q == '0) begin
            shreg_d    = pat_reg_q;
            bit_cnt_d  = LAST_BIT;
            rep_left_d = rep_left_q - 1'b1;
          end else begin
            gap_cnt_d  = gap_reg_q - 1'b1;
            rep_left_d = rep_left_q - 1'b1;
            state_d    = GAP;
          end
        end else begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          shreg_d   = pat_reg_q;
          bit_cnt_d = LAST_BIT;
          state_d   = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
    end

    sequence_valid_d = (state_d == SHIFT);
    sequence_out_d   = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
    busy_d           = (state_d == SHIFT) || (state_d == GAP);
    done_d           = (state_d == DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      shreg_q          <= '0;
      pat_reg_q        <= '0;
      bit_cnt_q        <= '0;
      rep_left_q       <= '0;
      gap_reg_q        <= '0;
      gap_cnt_q        <= '0;
      sequence_out_q   <= 1'b0;
      sequence_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      shreg_q          <= shreg_d;
      pat_reg_q        <= pat_reg_d;
      bit_cnt_q        <= bit_cnt_d;
      rep_left_q       <= rep_left_d;
      gap_reg_q        <= gap_reg_d;
      gap_cnt_q        <= gap_cnt_d;
      sequence_out_q   <= sequence_out_d;
      sequence_valid_q <= sequence_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign sequence_out   = sequence_out_q;
  assign sequence_valid = sequence_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Bench for the serial pattern transmitter: table of transactions checked
// cycle by cycle against a queue of expected outputs, plus corner cases.
module tb_sequence_generator_moore;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [7:0] repeat_count;
  logic [3:0] gap_cycles;
  logic       sequence_out;
  logic       sequence_valid;
  logic       busy;
  logic       done;

  int total;
  int bad;

  typedef struct {
    logic out;
    logic valid;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    logic [3:0] pattern;
    logic [7:0] rep;
    logic [3:0] gap;
    int         expValid;
  } vec_t;

  exp_t expq[$];
  vec_t vecs[7];

  sequence_generator_moore #(
    .WIDTH(4),
    .GAP_W(4),
    .REP_W(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .pattern       (pattern),
    .repeat_count  (repeat_count),
    .gap_cycles    (gap_cycles),
    .sequence_out  (sequence_out),
    .sequence_valid(sequence_valid),
    .busy          (busy),
    .done          (done)
  );

  // 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare all four outputs against one expected record
  task automatic checkOutput(input string name, input int idx, input exp_t e);
    logic [3:0] got;
    logic [3:0] want;
    got  = {sequence_out, sequence_valid, busy, done};
    want = {e.out, e.valid, e.busy, e.done};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got out/valid/busy/done=%b expected %b", name, idx, got, want);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic o, input logic v, input logic b, input logic d);
    exp_t e;
    e.out = o; e.valid = v; e.busy = b; e.done = d;
    return e;
  endfunction

  // Drive one start pulse and push the reference output stream for it
  task automatic applyStimulus(input logic [3:0] pat, input logic [7:0] rep, input logic [3:0] gap);
    @(negedge clock);
    pattern      = pat;
    repeat_count = rep;
    gap_cycles   = gap;
    start        = 1'b1;
    for (int f = 0; f <= int'(rep); f++) begin
      for (int b = 3; b >= 0; b--) expq.push_back(mk(pat[b], 1'b1, 1'b1, 1'b0));
      if (f < int'(rep))
        for (int g = 0; g < int'(gap); g++) expq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end
    expq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) expq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock);
  endtask

  // Pop and compare one record per cycle; optionally abort or disturb inputs
  task automatic runQueue(input string name, input int abortAt, input int disturbAt,
                          output int validCnt, output int doneCnt);
    int idx;
    exp_t e;
    idx = 0;
    validCnt = 0;
    doneCnt = 0;
    while (expq.size() > 0) begin
      @(negedge clock);
      if (idx == 0) start = 1'b0;
      e = expq.pop_front();
      checkOutput(name, idx, e);
      if (sequence_valid === 1'b1) validCnt++;
      if (done === 1'b1) doneCnt++;
      if (idx == abortAt) abort = 1'b1;
      if (idx == abortAt + 1) abort = 1'b0;
      if (idx == disturbAt) begin
        start = 1'b1; pattern = 4'b0100; repeat_count = 8'd5; gap_cycles = 4'd7;
      end
      if (idx == disturbAt + 1) start = 1'b0;
      idx++;
    end
  endtask

  initial begin
    int vc;
    int dc;
    exp_t z;
    total = 0;
    bad   = 0;
    z = mk(1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{4'b1011, 8'd0,   4'd0,  4};
    vecs[1] = '{4'b1011, 8'd2,   4'd0,  12};
    vecs[2] = '{4'b1011, 8'd1,   4'd3,  8};
    vecs[3] = '{4'b0110, 8'd0,   4'd0,  4};
    vecs[4] = '{4'b1001, 8'd3,   4'd1,  16};
    vecs[5] = '{4'b1111, 8'd1,   4'd15, 8};
    vecs[6] = '{4'b1100, 8'd255, 4'd0,  1024};

    // Reset held with start high: outputs stay 0
    reset = 1'b1; start = 1'b1; abort = 1'b0;
    pattern = 4'b1011; repeat_count = '0; gap_cycles = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("reset_hold", i, z);
      #8;
    end
    #4;
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("after_reset", i, z);
    end

    // Table of transactions
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pattern, vecs[i].rep, vecs[i].gap);
      runQueue($sformatf("vec%0d", i), -10, -10, vc, dc);
      checkCount($sformatf("vec%0d_valid_count", i), vc, vecs[i].expValid);
      checkCount($sformatf("vec%0d_done_count", i), dc, 1);
    end

    // Start and new pattern during a frame are ignored
    applyStimulus(4'b1011, 8'd0, 4'd0);
    runQueue("ignored_inputs", -10, 1, vc, dc);
    checkCount("ignored_valid_count", vc, 4);
    checkCount("ignored_done_count", dc, 1);

    // Abort after the second bit: idle next cycle, no done
    applyStimulus(4'b1011, 8'd1, 4'd2);
    expq.delete();
    expq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
    expq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) expq.push_back(z);
    runQueue("abort", 1, -10, vc, dc);
    checkCount("abort_done_count", dc, 0);
    applyStimulus(4'b1011, 8'd0, 4'd0);
    runQueue("after_abort", -10, -10, vc, dc);
    checkCount("after_abort_valid_count", vc, 4);

    // Abort wins over start in the same cycle
    @(negedge clock);
    start = 1'b1; abort = 1'b1; pattern = 4'b1111;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_vs_start", 0, z);
    @(negedge clock);
    checkOutput("abort_vs_start", 1, z);

    // Asynchronous reset mid-frame
    applyStimulus(4'b1011, 8'd0, 4'd0);
    expq.delete();
    @(negedge clock);
    start = 1'b0;
    checkOutput("reset_mid", 0, mk(1'b1, 1'b1, 1'b1, 1'b0));
    @(negedge clock);
    checkOutput("reset_mid", 1, mk(1'b0, 1'b1, 1'b1, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_async", 2, z);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_mid", 3, z);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("reset_mid_idle", i, z);
    end
    applyStimulus(4'b1011, 8'd1, 4'd1);
    runQueue("after_reset_mid", -10, -10, vc, dc);
    checkCount("after_reset_mid_valid_count", vc, 8);
    checkCount("after_reset_mid_done_count", dc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequence_generator_moore.md
Name: sequence_generator_moore

Overview:
- Serial pattern transmitter; the transmit-side counterpart of the serial sequence detector.
- Accepts a WIDTH-bit pattern on a start strobe and emits it MSB-first on a 1-bit serial line, one bit per clock.
- Supports programmable frame repeats and idle gaps between frames.
- Used to drive sequence_in of detector blocks and as a stimulus source on the board.

Parameters:
- WIDTH, 4, pattern length in bits (>=2).
- GAP_W, 4, width of gap_cycles.
- REP_W, 8, width of repeat_count.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous abort; forces IDLE.
- pattern  input  WIDTH  bits to send, MSB first; captured at start.
- repeat_count  input  REP_W  extra frames; total frames = repeat_count+1; captured at start.
- gap_cycles  input  GAP_W  idle cycles between frames; captured at start.
- sequence_out  output  1  serial data bit.
- sequence_valid  output  1  high while sequence_out carries a pattern bit.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- All outputs are registered and depend only on state and internal registers (Moore).
- Reset:
  - Asynchronous assertion forces state IDLE immediately.
  - sequence_out=0, sequence_valid=0, busy=0, done=0.
  - Internal shift register, bit counter, repeat counter and gap counter clear to 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Outputs all 0.
  - start=1 at edge k: capture pattern into shreg, repeat_count into rep_left, gap_cycles into gap_reg; set bit_cnt=WIDTH-1; go to SHIFT.
  - First bit appears on sequence_out in the cycle after edge k, with sequence_valid=1 and busy=1. Latency is 1 clock.
- SHIFT:
  - sequence_out = shreg MSB; sequence_valid=1; busy=1.
  - Each edge: shift shreg left by 1 and decrement bit_cnt.
  - When bit_cnt==0 (last bit of the frame is being driven):
    - rep_left==0 → DONE.
    - Else, gap_reg==0 → stay in SHIFT, reload the captured pattern, bit_cnt=WIDTH-1, rep_left-1. Back-to-back frames, no bubble.
    - Else → GAP with gap_cnt=gap_reg-1, and rep_left-1.
- GAP:
  - sequence_out=0, sequence_valid=0, busy=1.
  - Lasts exactly gap_reg cycles.
  - Then → SHIFT with the captured pattern reloaded and bit_cnt=WIDTH-1.
- DONE:
  - done=1 for exactly one cycle; busy=0, valid=0.
  - Then → IDLE unconditionally.
- start is ignored in SHIFT, GAP and DONE. It is not queued.
- Changes on pattern, repeat_count or gap_cycles after capture have no effect until the next accepted start.
- abort=1 at any edge: → IDLE; all outputs 0 the next cycle; no done pulse.
  - abort has priority over start in the same cycle.
- Reset mid-frame: outputs drop to 0 asynchronously; no done pulse. The next start after reset deassertion is accepted normally.
- A frame always sends all WIDTH bits unless aborted or reset. Total valid cycles = WIDTH*(repeat_count+1).
- Counter rules:
  - rep_left uses unsigned, non-wrapping decrement and is checked before decrementing.
  - Maximum repeat_count = 2^REP_W-1 gives 2^REP_W frames.

Test Plan:
- Reset: hold reset 30 ns with start=1 → all outputs 0 throughout. After release with start=0 → outputs stay 0.
- Single frame: pattern=4'b1011, repeat_count=0, gap_cycles=0, start pulse at edge k.
  - sequence_out=1,0,1,1 with sequence_valid=1 in cycles k+1..k+4.
  - busy=1 for those 4 cycles; done=1 only in cycle k+5; IDLE at k+6.
  - Feeding this into the 1011 detector → detector_out asserts once.
- Back-to-back: pattern=4'b1011, repeat_count=2, gap_cycles=0 → 12 contiguous valid bits 101110111011, then a single done pulse.
- Gapped: pattern=4'b1011, repeat_count=1, gap_cycles=3 → 1011 (valid), then 3 cycles of valid=0/out=0 with busy=1, then 1011, then done.
- Ignored inputs: during a frame pulse start and change pattern to 4'b0100 → serial output unchanged, no second frame, exactly one done.
- Abort/reset: assert abort after the 2nd bit → IDLE next cycle, no done. Then a new start sends the full pattern. Repeat with reset asynchronous mid-frame → outputs 0 without waiting for a clock edge.
